// File: rtl/duel_turn_controller_if.sv
// Bundles the request, health and commit signals between the duel turn
// controller (slave) and the player/arbiter side (master).
interface duel_turn_controller_if #(
  parameter int CNT_W = 6
);
  logic             start;
  logic             p1_req;
  logic [2:0]       p1_req_action;
  logic             p2_req;
  logic [2:0]       p2_req_action;
  logic [1:0]       p1_health;
  logic [1:0]       p2_health;
  logic [2:0]       action1;
  logic [2:0]       action2;
  logic             step;
  logic             p1_ack;
  logic             p2_ack;
  logic             round_active;
  logic [CNT_W-1:0] turn_count;
  logic [1:0]       winner;
  logic             done;

  modport master (
    output start, p1_req, p1_req_action, p2_req, p2_req_action, p1_health, p2_health,
    input  action1, action2, step, p1_ack, p2_ack, round_active, turn_count, winner, done
  );

  modport slave (
    input  start, p1_req, p1_req_action, p2_req, p2_req_action, p1_health, p2_health,
    output action1, action2, step, p1_ack, p2_ack, round_active, turn_count, winner, done
  );
endinterface

// File: rtl/duel_turn_controller.sv
// Sequences duel turns: collects both players' actions, commits them with a
// step strobe, waits for health to settle, then decides continue/KO/limit.
//
// state     | meaning
// S_IDLE    | no match running, waiting for start
// S_COLLECT | gathering action requests, timeout timer running
// S_COMMIT  | actions presented to player modules, step high
// S_SETTLE  | waiting for player health registers to update
// S_CHECK   | turn counted, KO / turn-limit decision
// S_OVER    | match finished, winner and done held
module duel_turn_controller #(
  parameter int TURN_TIMEOUT  = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_TURNS     = 32,
  parameter int CNT_W         = 6
) (
  input logic                   clk,
  input logic                   rst,
  duel_turn_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_COMMIT,
    S_SETTLE,
    S_CHECK,
    S_OVER
  } state_t;

  localparam logic [2:0] ACT_AWAIT = 3'b010;
  localparam int TW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t           r_state, w_state_n;
  logic [TW-1:0]    r_timer, w_timer_n;
  logic [SW-1:0]    r_settle, w_settle_n;
  logic             r_slot1_full, w_slot1_full_n;
  logic             r_slot2_full, w_slot2_full_n;
  logic [2:0]       r_slot1, w_slot1_n;
  logic [2:0]       r_slot2, w_slot2_n;
  logic [2:0]       r_action1, w_action1_n;
  logic [2:0]       r_action2, w_action2_n;
  logic             r_step, w_step_n;
  logic             r_p1_ack, w_p1_ack_n;
  logic             r_p2_ack, w_p2_ack_n;
  logic             r_round_active, w_round_active_n;
  logic [CNT_W-1:0] r_turn_count, w_turn_count_n;
  logic [1:0]       r_winner, w_winner_n;
  logic             r_done, w_done_n;

  logic             w_p1_take;
  logic             w_p2_take;
  logic             w_p1_dead;
  logic             w_p2_dead;
  logic [CNT_W-1:0] w_turn_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_settle       <= '0;
      r_slot1_full   <= 1'b0;
      r_slot2_full   <= 1'b0;
      r_slot1        <= ACT_AWAIT;
      r_slot2        <= ACT_AWAIT;
      r_action1      <= ACT_AWAIT;
      r_action2      <= ACT_AWAIT;
      r_step         <= 1'b0;
      r_p1_ack       <= 1'b0;
      r_p2_ack       <= 1'b0;
      r_round_active <= 1'b0;
      r_turn_count   <= '0;
      r_winner       <= 2'b00;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_timer        <= w_timer_n;
      r_settle       <= w_settle_n;
      r_slot1_full   <= w_slot1_full_n;
      r_slot2_full   <= w_slot2_full_n;
      r_slot1        <= w_slot1_n;
      r_slot2        <= w_slot2_n;
      r_action1      <= w_action1_n;
      r_action2      <= w_action2_n;
      r_step         <= w_step_n;
      r_p1_ack       <= w_p1_ack_n;
      r_p2_ack       <= w_p2_ack_n;
      r_round_active <= w_round_active_n;
      r_turn_count   <= w_turn_count_n;
      r_winner       <= w_winner_n;
      r_done         <= w_done_n;
    end
  end

  assign w_p1_take  = (r_state == S_COLLECT) && bus.p1_req && !r_slot1_full;
  assign w_p2_take  = (r_state == S_COLLECT) && bus.p2_req && !r_slot2_full;
  assign w_p1_dead  = (bus.p1_health == 2'd0);
  assign w_p2_dead  = (bus.p2_health == 2'd0);
  assign w_turn_inc = r_turn_count + CNT_W'(1);

  always_comb begin
    w_state_n      = r_state;
    w_timer_n      = '0;
    w_settle_n     = r_settle;
    w_slot1_full_n = 1'b0;
    w_slot2_full_n = 1'b0;
    w_slot1_n      = r_slot1;
    w_slot2_n      = r_slot2;
    w_action1_n    = r_action1;
    w_action2_n    = r_action2;
    w_step_n       = 1'b0;
    w_p1_ack_n     = 1'b0;
    w_p2_ack_n     = 1'b0;
    w_turn_count_n = r_turn_count;
    w_winner_n     = r_winner;

    case (r_state)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          w_state_n      = S_COLLECT;
          w_turn_count_n = '0;
          w_winner_n     = 2'b00;
        end
      end
      S_COLLECT: begin
        w_timer_n      = r_timer + TW'(1);
        w_slot1_full_n = r_slot1_full | w_p1_take;
        w_slot2_full_n = r_slot2_full | w_p2_take;
        w_slot1_n      = w_p1_take ? bus.p1_req_action : r_slot1;
        w_slot2_n      = w_p2_take ? bus.p2_req_action : r_slot2;
        w_p1_ack_n     = w_p1_take;
        w_p2_ack_n     = w_p2_take;
        // A request landing on the timeout cycle still beats the await default.
        if ((r_slot1_full && r_slot2_full) || (r_timer == TW'(TURN_TIMEOUT - 1))) begin
          w_state_n   = S_COMMIT;
          w_step_n    = 1'b1;
          w_action1_n = w_slot1_full_n ? w_slot1_n : ACT_AWAIT;
          w_action2_n = w_slot2_full_n ? w_slot2_n : ACT_AWAIT;
          w_settle_n  = SW'(SETTLE_CYCLES - 1);
        end
      end
      S_COMMIT: begin
        w_state_n = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_settle == '0) begin
          w_state_n = S_CHECK;
        end else begin
          w_settle_n = r_settle - SW'(1);
        end
      end
      S_CHECK: begin
        w_turn_count_n = w_turn_inc;
        if (w_p1_dead || w_p2_dead || (w_turn_inc == CNT_W'(MAX_TURNS))) begin
          w_state_n = S_OVER;
          if (w_p1_dead && w_p2_dead)               w_winner_n = 2'b11;
          else if (w_p2_dead)                       w_winner_n = 2'b01;
          else if (w_p1_dead)                       w_winner_n = 2'b10;
          else if (bus.p1_health > bus.p2_health)   w_winner_n = 2'b01;
          else if (bus.p2_health > bus.p1_health)   w_winner_n = 2'b10;
          else                                      w_winner_n = 2'b11;
        end else begin
          w_state_n = S_COLLECT;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    w_round_active_n = (w_state_n == S_COLLECT) || (w_state_n == S_COMMIT) ||
                       (w_state_n == S_SETTLE)  || (w_state_n == S_CHECK);
    w_done_n         = (w_state_n == S_OVER);
  end

  assign bus.action1      = r_action1;
  assign bus.action2      = r_action2;
  assign bus.step         = r_step;
  assign bus.p1_ack       = r_p1_ack;
  assign bus.p2_ack       = r_p2_ack;
  assign bus.round_active = r_round_active;
  assign bus.turn_count   = r_turn_count;
  assign bus.winner       = r_winner;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_duel_turn_controller.sv
// Directed bench for duel_turn_controller: reset, normal turns, timeout,
// duplicate requests, KO and turn-limit outcomes (MAX_TURNS = 3).
module tb_duel_turn_controller;
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  duel_turn_controller_if #(.CNT_W(CNT_W)) bus ();

  duel_turn_controller #(
    .TURN_TIMEOUT (16),
    .SETTLE_CYCLES(2),
    .MAX_TURNS    (3),
    .CNT_W        (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in a COLLECT cycle; both players answer at once. Returns on the
  // cycle after CHECK.
  task automatic quick_turn(input logic [2:0] a1, input logic [2:0] a2,
                            input logic [1:0] h1, input logic [1:0] h2);
    bus.p1_health = h1;
    bus.p2_health = h2;
    bus.p1_req = 1'b1; bus.p1_req_action = a1;
    bus.p2_req = 1'b1; bus.p2_req_action = a2;
    tick();
    check("qt_p1_ack", 32'(bus.p1_ack), 1);
    check("qt_p2_ack", 32'(bus.p2_ack), 1);
    bus.p1_req = 1'b0;
    bus.p2_req = 1'b0;
    tick();
    check("qt_step", 32'(bus.step), 1);
    check("qt_action1", 32'(bus.action1), 32'(a1));
    check("qt_action2", 32'(bus.action2), 32'(a2));
    tick();
    check("qt_step_drop", 32'(bus.step), 0);
    tick();
    tick();
    tick();
  endtask

  initial begin
    int p1_acks, p2_acks, step_at;
    logic [2:0] codes [5];
    codes[0] = 3'b011; codes[1] = 3'b100; codes[2] = 3'b101;
    codes[3] = 3'b110; codes[4] = 3'b111;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.p1_req = 1'b0; bus.p1_req_action = 3'b000;
    bus.p2_req = 1'b0; bus.p2_req_action = 3'b000;
    bus.p1_health = 2'd3; bus.p2_health = 2'd3;
    tick();
    tick();
    check("rst_action1", 32'(bus.action1), 2);
    check("rst_action2", 32'(bus.action2), 2);
    check("rst_step", 32'(bus.step), 0);
    check("rst_p1_ack", 32'(bus.p1_ack), 0);
    check("rst_p2_ack", 32'(bus.p2_ack), 0);
    check("rst_round_active", 32'(bus.round_active), 0);
    check("rst_turn_count", 32'(bus.turn_count), 0);
    check("rst_winner", 32'(bus.winner), 0);
    check("rst_done", 32'(bus.done), 0);
    rst = 1'b0;

    // Request in IDLE is ignored.
    bus.p1_req = 1'b1; bus.p1_req_action = 3'b001;
    tick();
    check("idle_req_no_ack", 32'(bus.p1_ack), 0);
    check("idle_stays", 32'(bus.round_active), 0);
    bus.p1_req = 1'b0;

    // Reset mid-SETTLE.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t1_round_active", 32'(bus.round_active), 1);
    bus.p1_req = 1'b1; bus.p1_req_action = 3'b001;
    bus.p2_req = 1'b1; bus.p2_req_action = 3'b111;
    tick();
    bus.p1_req = 1'b0; bus.p2_req = 1'b0;
    tick();
    check("t1_step", 32'(bus.step), 1);
    check("t1_action1", 32'(bus.action1), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t1_rst_step", 32'(bus.step), 0);
    check("t1_rst_action1", 32'(bus.action1), 2);
    check("t1_rst_action2", 32'(bus.action2), 2);
    check("t1_rst_turn_count", 32'(bus.turn_count), 0);
    check("t1_rst_round_active", 32'(bus.round_active), 0);
    tick();
    check("t1_idle_holds", 32'(bus.round_active), 0);

    // Normal turn, start at cycle 0.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.p1_req = 1'b1; bus.p1_req_action = 3'b000;
    tick();
    check("t2_p1_ack", 32'(bus.p1_ack), 1);
    check("t2_p2_ack_early", 32'(bus.p2_ack), 0);
    bus.p1_req = 1'b0;
    tick();
    check("t2_p1_ack_pulse", 32'(bus.p1_ack), 0);
    bus.p2_req = 1'b1; bus.p2_req_action = 3'b110;
    tick();
    check("t2_p2_ack", 32'(bus.p2_ack), 1);
    check("t2_no_step_yet", 32'(bus.step), 0);
    bus.p2_req = 1'b0;
    tick();
    check("t2_step", 32'(bus.step), 1);
    check("t2_action1", 32'(bus.action1), 0);
    check("t2_action2", 32'(bus.action2), 6);
    bus.start = 1'b1;
    tick();
    check("t2_step_pulse", 32'(bus.step), 0);
    tick();
    tick();
    check("t2_count_in_check", 32'(bus.turn_count), 0);
    tick();
    bus.start = 1'b0;
    check("t2_turn_count", 32'(bus.turn_count), 1);
    check("t2_round_active", 32'(bus.round_active), 1);
    check("t2_action1_hold", 32'(bus.action1), 0);

    // Timeout: only player 1 answers.
    bus.p1_req = 1'b1; bus.p1_req_action = 3'b001;
    p1_acks = 0; p2_acks = 0; step_at = -1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      bus.p1_req = 1'b0;
      if (bus.p1_ack) p1_acks++;
      if (bus.p2_ack) p2_acks++;
      if (bus.step && step_at < 0) step_at = i;
    end
    check("t3_step_cycle", step_at, 16);
    check("t3_action1", 32'(bus.action1), 1);
    check("t3_action2", 32'(bus.action2), 2);
    check("t3_p1_acks", p1_acks, 1);
    check("t3_p2_acks", p2_acks, 0);
    for (int i = 0; i < 4; i++) tick();
    check("t3_turn_count", 32'(bus.turn_count), 2);

    // Duplicate requests on the third (final) turn, healths 3/2.
    bus.p1_health = 2'd3; bus.p2_health = 2'd2;
    bus.p1_req = 1'b1; bus.p1_req_action = codes[0];
    bus.p2_req = 1'b1; bus.p2_req_action = 3'b000;
    p1_acks = 0; p2_acks = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus.p2_req = 1'b0;
      if (k < 5) bus.p1_req_action = codes[k];
      else bus.p1_req = 1'b0;
      if (bus.p1_ack) p1_acks++;
      if (bus.p2_ack) p2_acks++;
      if (k == 1) check("t4_both_ack", 32'(bus.p1_ack & bus.p2_ack), 1);
      if (k == 2) begin
        check("t4_step", 32'(bus.step), 1);
        check("t4_action1", 32'(bus.action1), 3);
        check("t4_action2", 32'(bus.action2), 0);
      end
    end
    check("t4_p1_acks", p1_acks, 1);
    check("t4_p2_acks", p2_acks, 1);
    tick();
    check("t6_limit_done", 32'(bus.done), 1);
    check("t6_limit_winner", 32'(bus.winner), 1);
    check("t6_limit_turns", 32'(bus.turn_count), 3);
    check("t6_limit_round_active", 32'(bus.round_active), 0);
    tick();
    check("over_hold_winner", 32'(bus.winner), 1);

    // Restart from OVER, equal healths at the limit give a draw.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t5_restart_turns", 32'(bus.turn_count), 0);
    check("t5_restart_winner", 32'(bus.winner), 0);
    check("t5_restart_done", 32'(bus.done), 0);
    quick_turn(3'b100, 3'b101, 2'd2, 2'd2);
    check("t6_draw_t1", 32'(bus.turn_count), 1);
    quick_turn(3'b111, 3'b011, 2'd2, 2'd2);
    check("t6_draw_t2", 32'(bus.turn_count), 2);
    quick_turn(3'b000, 3'b001, 2'd2, 2'd2);
    check("t6_draw_done", 32'(bus.done), 1);
    check("t6_draw_winner", 32'(bus.winner), 3);

    // Request on the timeout cycle wins over the await default.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.p1_health = 2'd3; bus.p2_health = 2'd3;
    bus.p1_req = 1'b1; bus.p1_req_action = 3'b101;
    p2_acks = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      bus.p1_req = 1'b0;
      bus.p2_req = 1'b0;
      if (bus.p2_ack) p2_acks++;
      if (i == 15) begin
        bus.p2_req = 1'b1; bus.p2_req_action = 3'b100;
      end
    end
    check("tb_edge_step", 32'(bus.step), 1);
    check("tb_edge_action1", 32'(bus.action1), 5);
    check("tb_edge_action2", 32'(bus.action2), 4);
    check("tb_edge_p2_ack", 32'(bus.p2_ack), 1);
    check("tb_edge_p2_acks", p2_acks, 1);
    for (int i = 0; i < 4; i++) tick();

    // KO outcomes.
    quick_turn(3'b000, 3'b001, 2'd2, 2'd0);
    check("t5_ko_done", 32'(bus.done), 1);
    check("t5_ko_winner", 32'(bus.winner), 1);
    check("t5_ko_turns", 32'(bus.turn_count), 2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t5_new_match_turns", 32'(bus.turn_count), 0);
    quick_turn(3'b011, 3'b011, 2'd0, 2'd2);
    check("ko_p2_wins", 32'(bus.winner), 2);
    check("ko_p2_turns", 32'(bus.turn_count), 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    quick_turn(3'b011, 3'b011, 2'd0, 2'd0);
    check("ko_double_draw", 32'(bus.winner), 3);
    check("ko_double_done", 32'(bus.done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
